adder_serial_nbit: RTL and testbench

//   Multi-cycle, parametrised N-bit adder built from the 1-bit full-adder equations.

---
 rtl/adder_serial_nbit.sv | 115 +++++++++++
 tb/tb_adder_serial_nbit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_serial_nbit.sv
// Serial N-bit adder: CHUNK bits per clock, least-significant chunk first, ripple inside a chunk.
// Latency: done pulses WIDTH/CHUNK edges after the accepting edge; results stay registered until the next completion.
// Backpressure: start is accepted only in IDLE/DONE (ignored while busy); abort cancels an in-flight add without a done pulse.
module adder_serial_nbit #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int STEPS = WIDTH / CHUNK;
    localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic             carry;
    logic [SW-1:0]    step;
    logic [31:0]      base;
    logic [CHUNK-1:0] ch_a;
    logic [CHUNK-1:0] ch_b;
    logic [CHUNK-1:0] ch_s;
    logic             rip_c;
    logic             ch_c;
    logic             ch_msb_c;
    logic             last_step;

    // Ripple the current chunk; ch_msb_c ends up as the carry into the chunk's top bit,
    // which on the final chunk is the carry into the word MSB used for signed overflow.
    always_comb begin
        base     = 32'(step) * 32'(CHUNK);
        ch_a     = op_a[base +: CHUNK];
        ch_b     = op_b[base +: CHUNK];
        ch_s     = '0;
        rip_c    = carry;
        ch_msb_c = carry;
        for (int i = 0; i < CHUNK; i++) begin
            ch_msb_c = rip_c;
            ch_s[i]  = ch_a[i] ^ ch_b[i] ^ rip_c;
            rip_c    = (ch_a[i] & ch_b[i]) | (ch_a[i] & rip_c) | (ch_b[i] & rip_c);
        end
        ch_c                 = rip_c;
        acc_nxt              = acc;
        acc_nxt[base +: CHUNK] = ch_s;
    end

    assign last_step = (step == SW'(STEPS - 1));
    assign busy      = (state == S_ADD);
    assign done      = (state == S_DONE);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= S_IDLE;
            op_a      <= '0;
            op_b      <= '0;
            acc       <= '0;
            carry     <= 1'b0;
            step      <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start && !abort) begin
                        op_a  <= a;
                        op_b  <= b;
                        carry <= carry_in;
                        step  <= '0;
                        acc   <= '0;
                        state <= S_ADD;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_ADD: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else begin
                        acc   <= acc_nxt;
                        carry <= ch_c;
                        if (last_step) begin
                            step      <= '0;
                            sum       <= acc_nxt;
                            carry_out <= ch_c;
                            overflow  <= ch_msb_c ^ ch_c;
                            state     <= S_DONE;
                        end else begin
                            step <= step + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_serial_nbit.sv
// Three configurations (16/4, 8/8, 8/1) driven with directed and random adds, checked against an arithmetic model.
module tb_adder_serial_nbit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        n_rst;
    logic        start [3];
    logic        abort [3];
    logic        cin   [3];
    logic [15:0] a     [3];
    logic [15:0] b     [3];
    logic        busy_w [3];
    logic        done_w [3];
    logic        cout_w [3];
    logic        ovf_w  [3];
    logic [15:0] sum0;
    logic [7:0]  sum1;
    logic [7:0]  sum2;

    int wid   [3] = '{16, 8, 8};
    int steps [3] = '{4, 1, 8};

    logic [15:0] m_sum  [3];
    logic        m_cout [3];
    logic        m_ovf  [3];
    logic [15:0] p_sum  [3];
    logic        p_cout [3];
    logic        p_ovf  [3];

    int n_cmp = 0;
    int n_bad = 0;

    adder_serial_nbit #(.WIDTH(16), .CHUNK(4)) u_w16c4 (
        .clk(clk), .n_rst(n_rst), .start(start[0]), .abort(abort[0]),
        .a(a[0]), .b(b[0]), .carry_in(cin[0]),
        .busy(busy_w[0]), .done(done_w[0]), .sum(sum0),
        .carry_out(cout_w[0]), .overflow(ovf_w[0]));

    adder_serial_nbit #(.WIDTH(8), .CHUNK(8)) u_w8c8 (
        .clk(clk), .n_rst(n_rst), .start(start[1]), .abort(abort[1]),
        .a(a[1][7:0]), .b(b[1][7:0]), .carry_in(cin[1]),
        .busy(busy_w[1]), .done(done_w[1]), .sum(sum1),
        .carry_out(cout_w[1]), .overflow(ovf_w[1]));

    adder_serial_nbit #(.WIDTH(8), .CHUNK(1)) u_w8c1 (
        .clk(clk), .n_rst(n_rst), .start(start[2]), .abort(abort[2]),
        .a(a[2][7:0]), .b(b[2][7:0]), .carry_in(cin[2]),
        .busy(busy_w[2]), .done(done_w[2]), .sum(sum2),
        .carry_out(cout_w[2]), .overflow(ovf_w[2]));

    function automatic logic [15:0] rd_sum(input int w);
        case (w)
            0:       return sum0;
            1:       return {8'h00, sum1};
            default: return {8'h00, sum2};
        endcase
    endfunction

    function automatic logic [15:0] wmask(input int w);
        return 16'((32'd1 << wid[w]) - 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic, signed overflow from the true signed sum's range.
    function automatic void model(input int w, input logic [15:0] av, input logic [15:0] bv,
                                  input logic cv, output logic [15:0] s, output logic co,
                                  output logic ov);
        longint tot, half, sa, sb, ss;
        tot  = longint'(av) + longint'(bv) + longint'(cv);
        s    = 16'(tot % (longint'(1) << w));
        co   = ((tot >> w) & 1) != 0;
        half = longint'(1) << (w - 1);
        sa   = (longint'(av) >= half) ? longint'(av) - 2 * half : longint'(av);
        sb   = (longint'(bv) >= half) ? longint'(bv) - 2 * half : longint'(bv);
        ss   = sa + sb + longint'(cv);
        ov   = (ss >= half) || (ss < -half);
    endfunction

    task automatic start_op(input int w, input logic [15:0] av, input logic [15:0] bv, input logic cv);
        logic [15:0] s;
        logic co, ov;
        a[w]     = av & wmask(w);
        b[w]     = bv & wmask(w);
        cin[w]   = cv;
        start[w] = 1'b1;
        model(wid[w], a[w], b[w], cv, s, co, ov);
        p_sum[w]  = s;
        p_cout[w] = co;
        p_ovf[w]  = ov;
        @(negedge clk);
        start[w] = 1'b0;
        a[w]     = 16'($urandom);
        b[w]     = 16'($urandom);
        cin[w]   = 1'($urandom);
        chk($sformatf("i%0d busy_after_start", w), 32'(busy_w[w]), 32'd1);
        chk($sformatf("i%0d done_after_start", w), 32'(done_w[w]), 32'd0);
    endtask

    task automatic wait_done(input int w, input bit spurious);
        int k = 0;
        int bc = 0;
        while (!done_w[w] && k < 40) begin
            if (busy_w[w]) bc++;
            chk($sformatf("i%0d sum_hold", w), 32'(rd_sum(w)), 32'(m_sum[w]));
            if (spurious && k == 1) begin
                start[w] = 1'b1;
                a[w]     = 16'($urandom);
                b[w]     = 16'($urandom);
            end else begin
                start[w] = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        start[w] = 1'b0;
        chk($sformatf("i%0d latency", w), 32'(k), 32'(steps[w]));
        chk($sformatf("i%0d busy_cycles", w), 32'(bc), 32'(steps[w]));
        chk($sformatf("i%0d busy_in_done", w), 32'(busy_w[w]), 32'd0);
        chk($sformatf("i%0d sum", w), 32'(rd_sum(w)), 32'(p_sum[w]));
        chk($sformatf("i%0d carry_out", w), 32'(cout_w[w]), 32'(p_cout[w]));
        chk($sformatf("i%0d overflow", w), 32'(ovf_w[w]), 32'(p_ovf[w]));
        m_sum[w]  = p_sum[w];
        m_cout[w] = p_cout[w];
        m_ovf[w]  = p_ovf[w];
    endtask

    task automatic idle_chk(input int w);
        @(negedge clk);
        chk($sformatf("i%0d done_one_cycle", w), 32'(done_w[w]), 32'd0);
        chk($sformatf("i%0d busy_idle", w), 32'(busy_w[w]), 32'd0);
        chk($sformatf("i%0d sum_idle", w), 32'(rd_sum(w)), 32'(m_sum[w]));
    endtask

    task automatic run(input int w, input logic [15:0] av, input logic [15:0] bv, input logic cv);
        start_op(w, av, bv, cv);
        wait_done(w, 1'b0);
        idle_chk(w);
    endtask

    task automatic zero_chk(input string tag);
        for (int w = 0; w < 3; w++) begin
            chk($sformatf("i%0d %s busy", w, tag), 32'(busy_w[w]), 32'd0);
            chk($sformatf("i%0d %s done", w, tag), 32'(done_w[w]), 32'd0);
            chk($sformatf("i%0d %s sum", w, tag), 32'(rd_sum(w)), 32'd0);
            chk($sformatf("i%0d %s cout", w, tag), 32'(cout_w[w]), 32'd0);
            chk($sformatf("i%0d %s ovf", w, tag), 32'(ovf_w[w]), 32'd0);
        end
    endtask

    // Asserts reset between edges and checks outputs clear without waiting for a clock.
    task automatic mid_reset(input string tag);
        #2;
        n_rst = 1'b0;
        for (int w = 0; w < 3; w++) begin
            start[w] = 1'b0;
            abort[w] = 1'b0;
            m_sum[w] = '0;
            m_cout[w] = 1'b0;
            m_ovf[w] = 1'b0;
        end
        #1;
        zero_chk(tag);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        zero_chk({tag, "_rel"});
    endtask

    initial begin
        n_rst = 1'b0;
        for (int w = 0; w < 3; w++) begin
            start[w] = 1'b0;
            abort[w] = 1'b0;
            cin[w]   = 1'b0;
            a[w]     = '0;
            b[w]     = '0;
            m_sum[w] = '0;
            m_cout[w] = 1'b0;
            m_ovf[w] = 1'b0;
        end
        #1;
        zero_chk("reset");
        @(negedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);

        // Directed arithmetic corner cases on every configuration.
        run(0, 16'h1234, 16'h4321, 1'b0);
        run(0, 16'hFFFF, 16'h0001, 1'b0);
        run(0, 16'h7FFF, 16'h0000, 1'b1);
        run(0, 16'h8000, 16'h8000, 1'b0);
        for (int w = 1; w < 3; w++) begin
            run(w, 16'h0012, 16'h0043, 1'b0);
            run(w, 16'h00FF, 16'h0001, 1'b0);
            run(w, 16'h007F, 16'h0000, 1'b1);
            run(w, 16'h0080, 16'h0080, 1'b0);
        end

        // Abort at step 2 leaves the previous result untouched and never pulses done.
        run(0, 16'h1234, 16'h4321, 1'b0);
        start_op(0, 16'h1111, 16'h2222, 1'b0);
        repeat (2) @(negedge clk);
        abort[0] = 1'b1;
        @(negedge clk);
        abort[0] = 1'b0;
        chk("abort busy", 32'(busy_w[0]), 32'd0);
        chk("abort done", 32'(done_w[0]), 32'd0);
        chk("abort sum", 32'(sum0), 32'h5555);
        repeat (5) idle_chk(0);

        // Start pulsed again mid-operation must not disturb the add in flight.
        start_op(0, 16'hA5A5, 16'h0F0F, 1'b1);
        wait_done(0, 1'b1);
        idle_chk(0);

        // Back-to-back: new start in the DONE cycle.
        start_op(0, 16'h0101, 16'h0202, 1'b0);
        wait_done(0, 1'b0);
        start_op(0, 16'hFFF0, 16'h0020, 1'b1);
        wait_done(0, 1'b0);
        idle_chk(0);

        // Reset in the middle of an add, then a clean 3 + 4.
        start_op(0, 16'h4444, 16'h3333, 1'b0);
        @(negedge clk);
        mid_reset("rst_in_add");
        run(0, 16'd3, 16'd4, 1'b0);
        chk("post_reset sum", 32'(sum0), 32'd7);

        // Random traffic, sometimes chained back-to-back in the DONE cycle.
        for (int w = 0; w < 3; w++) begin
            for (int r = 0; r < 25; r++) begin
                start_op(w, 16'($urandom), 16'($urandom), 1'($urandom));
                wait_done(w, 1'b0);
                if ($urandom_range(0, 1) == 1) idle_chk(w);
            end
            idle_chk(w);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
